// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT/IFFT sequencer: one butterfly per cycle, read/twiddle address
// generation, and a delayed write-back path with optional per-stage 1/2 scaling.
module fft_seq_ctrl #(
    parameter int MAX_LOG2N = 10,
    parameter int DW        = 16,
    parameter int BF_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [3:0]                  log2n,
    input  logic                        scale_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        rd_en,
    output logic [MAX_LOG2N-1:0]        rd_addr1,
    output logic [MAX_LOG2N-1:0]        rd_addr2,
    output logic [MAX_LOG2N-2:0]        tw_addr,
    input  logic signed [DW-1:0]        y1_re,
    input  logic signed [DW-1:0]        y1_im,
    input  logic signed [DW-1:0]        y2_re,
    input  logic signed [DW-1:0]        y2_im,
    output logic                        wr_en,
    output logic [MAX_LOG2N-1:0]        wr_addr1,
    output logic [MAX_LOG2N-1:0]        wr_addr2,
    output logic signed [DW-1:0]        wd1_re,
    output logic signed [DW-1:0]        wd1_im,
    output logic signed [DW-1:0]        wd2_re,
    output logic signed [DW-1:0]        wd2_im
);

    localparam int WB_LAT = 1 + BF_LAT;
    localparam int AW     = MAX_LOG2N;
    localparam int TW     = MAX_LOG2N - 1;
    localparam int CW     = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    localparam logic [3:0] MAXL = 4'(MAX_LOG2N);
    localparam logic [3:0] TWSH = 4'(MAX_LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t          state, state_n;
    logic [3:0]      s, s_n;
    logic [AW-1:0]   b, b_n;
    logic [CW-1:0]   dcnt, dcnt_n;
    logic [3:0]      n_log, n_log_n;
    logic            scale_q, scale_n;
    logic            err_q, err_n;

    logic            legal;
    logic            flush;
    logic [AW-1:0]   b_last;
    logic [AW-1:0]   half;
    logic [AW-1:0]   pos;
    logic [AW-1:0]   grp;
    logic [AW-1:0]   addr1_c;
    logic [AW-1:0]   addr2_c;
    logic [TW-1:0]   tw_c;

    logic [WB_LAT-1:0] v_sr;
    logic [AW-1:0]     a1_sr [WB_LAT];
    logic [AW-1:0]     a2_sr [WB_LAT];

    logic signed [DW-1:0] y1_re_h, y1_im_h, y2_re_h, y2_im_h;

    assign legal  = (log2n != 4'd0) && (log2n <= MAXL);
    assign flush  = abort && (state != IDLE);
    assign b_last = (AW'(1) << (n_log - 4'd1)) - AW'(1);

    // Butterfly index b splits into group and position within the current stage's span.
    assign half    = AW'(1) << s;
    assign pos     = b & (half - AW'(1));
    assign grp     = b >> s;
    assign addr1_c = (grp << (s + 4'd1)) | pos;
    assign addr2_c = addr1_c + half;
    assign tw_c    = TW'(pos) << (TWSH - s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            b       <= '0;
            dcnt    <= '0;
            n_log   <= '0;
            scale_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            b       <= b_n;
            dcnt    <= dcnt_n;
            n_log   <= n_log_n;
            scale_q <= scale_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        b_n     = b;
        dcnt_n  = dcnt;
        n_log_n = n_log;
        scale_n = scale_q;
        err_n   = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            state_n = ISSUE;
                            s_n     = '0;
                            b_n     = '0;
                            n_log_n = log2n;
                            scale_n = scale_en;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (b == b_last) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end else begin
                        b_n = b + AW'(1);
                    end
                end
                // Hold off the next stage until the last write of this one has landed.
                DRAIN: begin
                    if (dcnt == CW'(WB_LAT - 1)) begin
                        if ((s + 4'd1) < n_log) begin
                            state_n = ISSUE;
                            s_n     = s + 4'd1;
                            b_n     = '0;
                        end else begin
                            state_n = FIN;
                        end
                    end else begin
                        dcnt_n = dcnt + CW'(1);
                    end
                end
                FIN: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy     = (state == ISSUE) || (state == DRAIN);
    assign done     = (state == FIN);
    assign err      = err_q;
    assign rd_en    = (state == ISSUE);
    assign rd_addr1 = rd_en ? addr1_c : '0;
    assign rd_addr2 = rd_en ? addr2_c : '0;
    assign tw_addr  = rd_en ? tw_c : '0;

    // Write strobe and addresses trail the reads by the full RAM + butterfly latency.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_sr <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                a1_sr[i] <= '0;
                a2_sr[i] <= '0;
            end
        end else begin
            v_sr[0]  <= rd_en;
            a1_sr[0] <= rd_addr1;
            a2_sr[0] <= rd_addr2;
            for (int i = 1; i < WB_LAT; i++) begin
                v_sr[i]  <= v_sr[i-1];
                a1_sr[i] <= a1_sr[i-1];
                a2_sr[i] <= a2_sr[i-1];
            end
        end
    end

    assign wr_en    = v_sr[WB_LAT-1];
    assign wr_addr1 = a1_sr[WB_LAT-1];
    assign wr_addr2 = a2_sr[WB_LAT-1];

    assign y1_re_h = y1_re >>> 1;
    assign y1_im_h = y1_im >>> 1;
    assign y2_re_h = y2_re >>> 1;
    assign y2_im_h = y2_im >>> 1;

    always_comb begin
        wd1_re = '0;
        wd1_im = '0;
        wd2_re = '0;
        wd2_im = '0;
        if (wr_en) begin
            wd1_re = scale_q ? y1_re_h : y1_re;
            wd1_im = scale_q ? y1_im_h : y1_im;
            wd2_re = scale_q ? y2_re_h : y2_re;
            wd2_im = scale_q ? y2_im_h : y2_im;
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: error table, hand-checked 8-point run, and randomized
// runs compared cycle by cycle against a loop-based FFT schedule model.
module tb_fft_seq_ctrl;

    localparam int MAX_LOG2N = 10;
    localparam int DW        = 16;
    localparam int BF_LAT    = 2;
    localparam int WB_LAT    = 3;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [3:0]           log2n;
    logic                 scale_en;
    logic                 busy, done, err, rd_en, wr_en;
    logic [9:0]           rd_addr1, rd_addr2, wr_addr1, wr_addr2;
    logic [8:0]           tw_addr;
    logic signed [DW-1:0] y1_re, y1_im, y2_re, y2_im;
    logic signed [DW-1:0] wd1_re, wd1_im, wd2_re, wd2_im;

    int vectors = 0;
    int miscompares = 0;

    fft_seq_ctrl #(.MAX_LOG2N(MAX_LOG2N), .DW(DW), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .log2n(log2n),
        .scale_en(scale_en), .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .tw_addr(tw_addr),
        .y1_re(y1_re), .y1_im(y1_im), .y2_re(y2_re), .y2_im(y2_im),
        .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
        .wd1_re(wd1_re), .wd1_im(wd1_im), .wd2_re(wd2_re), .wd2_im(wd2_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       rd_en;
        logic [9:0] rd_addr1;
        logic [9:0] rd_addr2;
        logic [8:0] tw_addr;
        logic       wr_en;
        logic [9:0] wr_addr1;
        logic [9:0] wr_addr2;
        logic [15:0] wd1_re;
        logic [15:0] wd1_im;
        logic [15:0] wd2_re;
        logic [15:0] wd2_im;
    } out_t;

    typedef struct packed {
        logic       rd;
        logic [9:0] a1;
        logic [9:0] a2;
        logic [8:0] tw;
    } rd_t;

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] l2;
        logic       exp_err;
    } vec_t;

    rd_t  trace[$];
    vec_t tbl[5];

    function automatic out_t snap();
        out_t o;
        o = '{busy, done, err, rd_en, rd_addr1, rd_addr2, tw_addr, wr_en, wr_addr1, wr_addr2,
              wd1_re, wd1_im, wd2_re, wd2_im};
        return o;
    endfunction

    function automatic logic [15:0] half_floor(logic signed [15:0] y);
        int v;
        v = y;
        if (v >= 0) return 16'(v / 2);
        return 16'(-((-v + 1) / 2));
    endfunction

    task automatic check_output(string name, out_t act, out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got busy=%0b done=%0b err=%0b rd=%0b a1=%0d a2=%0d tw=%0d wr=%0b wa1=%0d wa2=%0d wd=%h/%h/%h/%h, want busy=%0b done=%0b err=%0b rd=%0b a1=%0d a2=%0d tw=%0d wr=%0b wa1=%0d wa2=%0d wd=%h/%h/%h/%h",
                     name, act.busy, act.done, act.err, act.rd_en, act.rd_addr1, act.rd_addr2,
                     act.tw_addr, act.wr_en, act.wr_addr1, act.wr_addr2, act.wd1_re, act.wd1_im,
                     act.wd2_re, act.wd2_im, exp.busy, exp.done, exp.err, exp.rd_en, exp.rd_addr1,
                     exp.rd_addr2, exp.tw_addr, exp.wr_en, exp.wr_addr1, exp.wr_addr2, exp.wd1_re,
                     exp.wd1_im, exp.wd2_re, exp.wd2_im);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(logic st, logic ab, logic rs, logic [3:0] l2, logic sc);
        start    = st;
        abort    = ab;
        rst      = rs;
        log2n    = l2;
        scale_en = sc;
    endtask

    // Schedule model: classic nested FFT loops over groups and in-group offsets, then a drain gap.
    task automatic build_trace(int l2);
        rd_t e;
        int  n, half, stride;
        trace.delete();
        n = 1 << l2;
        for (int s = 0; s < l2; s++) begin
            half   = 1 << s;
            stride = 1 << (MAX_LOG2N - 1 - s);
            for (int j = 0; j < n; j += 2 * half) begin
                for (int k = 0; k < half; k++) begin
                    e.rd = 1'b1;
                    e.a1 = 10'(j + k);
                    e.a2 = 10'(j + k + half);
                    e.tw = 9'(k * stride);
                    trace.push_back(e);
                end
            end
            for (int d = 0; d < WB_LAT; d++) trace.push_back('0);
        end
    endtask

    // stop_kind: 0 = abort, 1 = rst, 2 = both, applied in cycle stop_at (negative = none).
    task automatic run_check(int l2, logic sc, int stop_at, int stop_kind, string name);
        out_t e;
        rd_t  r;
        int   len, last, busy_cnt, w;
        logic stopped;
        build_trace(l2);
        len = trace.size();
        busy_cnt = 0;
        last = (stop_at >= 0) ? stop_at + 8 : len + 1;
        @(posedge clk); #1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'(l2), sc);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            apply_stimulus((c < len && (stop_at < 0 || c < stop_at)) ? 1'($urandom_range(0, 1)) : 1'b0,
                           (c == stop_at) && (stop_kind != 1),
                           (c == stop_at) && (stop_kind != 0),
                           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            y1_re = 16'($urandom); y1_im = 16'($urandom);
            y2_re = 16'($urandom); y2_im = 16'($urandom);
            @(negedge clk);
            stopped = (stop_at >= 0) && (c > stop_at);
            e = '0;
            if (!stopped) begin
                e.busy = (c < len);
                e.done = (c == len);
                if (c < len && trace[c].rd) begin
                    e.rd_en = 1'b1;
                    e.rd_addr1 = trace[c].a1;
                    e.rd_addr2 = trace[c].a2;
                    e.tw_addr  = trace[c].tw;
                end
                w = c - WB_LAT;
                if (w >= 0 && w < len) begin
                    r = trace[w];
                    if (r.rd) begin
                        e.wr_en    = 1'b1;
                        e.wr_addr1 = r.a1;
                        e.wr_addr2 = r.a2;
                        e.wd1_re   = sc ? half_floor(y1_re) : y1_re;
                        e.wd1_im   = sc ? half_floor(y1_im) : y1_im;
                        e.wd2_re   = sc ? half_floor(y2_re) : y2_re;
                        e.wd2_im   = sc ? half_floor(y2_im) : y2_im;
                    end
                end
            end
            check_output($sformatf("%s c%0d", name, c), snap(), e);
            if (busy) busy_cnt++;
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        if (stop_at < 0) check_val({name, " busy_cycles"}, busy_cnt, l2 * ((1 << l2) / 2 + WB_LAT));
    endtask

    // 8-point run with fixed butterfly outputs, checked against hand-derived pairs and twiddles.
    task automatic hand_run3();
        int exp_a1[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int exp_a2[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int exp_tw[12] = '{0, 0, 0, 0, 0, 256, 0, 256, 0, 128, 256, 384};
        int k, dones, writes;
        k = 0; dones = 0; writes = 0;
        @(posedge clk); #1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
        y1_re = -16'sd3; y1_im = 16'sd7; y2_re = -16'sd8; y2_im = 16'sd5;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (rd_en) begin
                if (k < 12) begin
                    check_val($sformatf("hand rd_addr1 #%0d", k), int'(rd_addr1), exp_a1[k]);
                    check_val($sformatf("hand rd_addr2 #%0d", k), int'(rd_addr2), exp_a2[k]);
                    check_val($sformatf("hand tw_addr #%0d", k), int'(tw_addr), exp_tw[k]);
                end
                k++;
            end
            if (wr_en) begin
                if (writes == 0) begin
                    check_val("hand wd1_re scaled", int'(wd1_re), -2);
                    check_val("hand wd2_im scaled", int'(wd2_im), 2);
                end
                writes++;
            end
            if (done) dones++;
        end
        check_val("hand read count", k, 12);
        check_val("hand write count", writes, 12);
        check_val("hand done pulses", dones, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        out_t e;
        tbl[0] = '{1'b1, 1'b0, 4'd0,  1'b1};
        tbl[1] = '{1'b1, 1'b0, 4'd11, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 4'd15, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 4'd5,  1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'd4,  1'b0};

        apply_stimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        y1_re = '0; y1_im = '0; y2_re = '0; y2_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset", snap(), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply_stimulus(tbl[i].start, tbl[i].abort, 1'b0, tbl[i].l2, 1'b1);
            @(posedge clk); #1;
            apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            @(negedge clk);
            e = '0;
            e.err = tbl[i].exp_err;
            check_output($sformatf("table %0d err", i), snap(), e);
            @(posedge clk); #1;
            @(negedge clk);
            check_output($sformatf("table %0d after", i), snap(), '0);
        end

        hand_run3();
        run_check(3, 1'b0, -1, 0, "n8 pass");
        run_check(1, 1'b1, -1, 0, "n2");
        for (int i = 0; i < 4; i++) begin
            run_check($urandom_range(1, 7), 1'($urandom_range(0, 1)), -1, 0, $sformatf("rand%0d", i));
        end
        run_check(6, 1'b1, 45, 0, "n64 abort");
        run_check(6, 1'b0, -1, 0, "n64 fresh");
        run_check(5, 1'b1, 20, 1, "n32 rst");
        run_check(4, 1'b0, 5, 2, "n16 rst+abort");
        run_check(10, 1'b1, -1, 0, "n1024");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
